reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter N_DOMAINS, default 4: number of sequenced reset domains (2..16).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 16: consecutive pll_locked samples required before the first release (>=1).
REQ-003 SHALL have parameter STEP_CYCLES, default 8: cycles between successive domain releases (>=1).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rstb_in  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-006 pll_locked  input  1  clock-generator lock indication, already synchronized to clk.
REQ-007 sw_rst_req  input  1  single-cycle software request to re-run the full sequence.
REQ-008 rstb_out  output  N_DOMAINS  active-low per-domain resets; bit 0 releases first.
REQ-009 seq_done  output  1  high while all domains are released.
REQ-010 seq_state  output  2  current state: 00 ASSERT, 01 RELEASE, 10 DONE.
REQ-011 lock_loss_cnt  output  8  saturating count of lock-loss events since reset.

Function
REQ-012 SHALL register every output; no combinational path from any input to any output.
REQ-013 SHALL implement FSM states ASSERT, RELEASE and DONE.
REQ-014 ASSERT SHALL drive rstb_out all-zero and seq_done 0.
REQ-015 In ASSERT, lock_cnt SHALL increment on each cycle pll_locked=1 and clear to 0 on any cycle pll_locked=0.
REQ-016 When pll_locked=1 is sampled for the LOCK_STABLE_CYCLES-th consecutive cycle, that same edge SHALL set rstb_out[0]=1, enter RELEASE and clear step_cnt.
REQ-017 In RELEASE, every STEP_CYCLES cycles the next-higher rstb_out bit SHALL go to 1; bits already released stay 1.
REQ-018 Release order SHALL be strictly ascending in bit index, one bit per step.
REQ-019 The edge that releases bit N_DOMAINS-1 SHALL enter DONE and set seq_done=1.
REQ-020 In DONE, outputs SHALL hold until lock loss, sw_rst_req or rstb_in=0.
REQ-021 Lock loss: pll_locked=0 sampled in RELEASE or DONE SHALL, on that edge, clear all rstb_out bits, clear seq_done, clear both counters and enter ASSERT.
REQ-022 Each lock-loss transition per REQ-021 SHALL increment lock_loss_cnt by 1, saturating at 255.
REQ-023 pll_locked=0 while in ASSERT SHALL NOT increment lock_loss_cnt.
REQ-024 sw_rst_req=1 in RELEASE or DONE SHALL act as in REQ-021, except that it SHALL NOT increment lock_loss_cnt.
REQ-025 sw_rst_req=1 in ASSERT SHALL clear lock_cnt, restarting the stability window.
REQ-026 If sw_rst_req=1 and pll_locked=0 occur in the same cycle in RELEASE or DONE, the transition SHALL count as a lock loss (+1).
REQ-027 Total assertion time after any re-entry to ASSERT SHALL be at least LOCK_STABLE_CYCLES cycles.
REQ-028 Counter widths SHALL be $clog2-sized from the parameters; counters SHALL NOT wrap within a state.

Reset
REQ-029 rstb_in=0 sampled SHALL set: state ASSERT, rstb_out all-zero, seq_done 0, seq_state 00, lock_cnt 0, step_cnt 0, lock_loss_cnt 0.
REQ-030 rstb_in=0 SHALL take priority over all other inputs, including mid-sequence.
REQ-031 Sequencing SHALL begin with the first edge at which rstb_in=1 is sampled.

Verification (defaults N=4, L=16, S=8; edge 1 = first edge with rstb_in=1)
REQ-032 pll_locked=1 from edge 1 -> rstb_out 0001 after edge 16, 0011 after 24, 0111 after 32, 1111 plus seq_done=1 and seq_state=10 after 40.
REQ-033 pll_locked drops for 1 cycle at edge 10, then stays high -> lock_cnt restarts; rstb_out[0] rises after edge 26; lock_loss_cnt stays 0.
REQ-034 In DONE, pll_locked=0 for 1 cycle -> rstb_out=0000, seq_done=0 and lock_loss_cnt=1 on that edge; full sequence reruns; 1111 reached 40 cycles after relock.
REQ-035 sw_rst_req pulse while rstb_out=0011 -> 0000 on that edge; lock_loss_cnt unchanged; rstb_out[0] rises 16 cycles later.
REQ-036 rstb_in=0 for 1 cycle while rstb_out=0111 -> all outputs and counters reset on that edge; sequence restarts from edge 1.
REQ-037 Force 300 lock-loss events from DONE -> lock_loss_cnt saturates at 255 and does not wrap.

Source files
------------

// File: rtl/reset_sequencer.sv
// Power-on / lock-driven reset sequencer: holds every domain in reset until the
// PLL has been stably locked, then releases the domains one at a time, bit 0 first.
module reset_sequencer #(
  parameter int N_DOMAINS          = 4,
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int STEP_CYCLES        = 8
) (
  input  logic                 clk,
  input  logic                 rstb_in,
  input  logic                 pll_locked,
  input  logic                 sw_rst_req,
  output logic [N_DOMAINS-1:0] rstb_out,
  output logic                 seq_done,
  output logic [1:0]           seq_state,
  output logic [7:0]           lock_loss_cnt
);

  localparam int LW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int SW = $clog2(STEP_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'b00,
    ST_RELEASE = 2'b01,
    ST_DONE    = 2'b10
  } state_t;

  state_t        state;
  logic [LW-1:0] lock_cnt;
  logic [SW-1:0] step_cnt;

  // The state register is itself the registered seq_state output.
  assign seq_state = state;

  always_ff @(posedge clk) begin
    if (!rstb_in) begin
      state         <= ST_ASSERT;
      rstb_out      <= '0;
      seq_done      <= 1'b0;
      lock_cnt      <= '0;
      step_cnt      <= '0;
      lock_loss_cnt <= '0;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (sw_rst_req || !pll_locked) begin
            lock_cnt <= '0;
          end else if (lock_cnt == LOCK_LAST) begin
            lock_cnt <= '0;
            step_cnt <= '0;
            rstb_out <= N_DOMAINS'(1);
            state    <= ST_RELEASE;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end
        default: begin
          if (!pll_locked || sw_rst_req) begin
            // Lock loss wins over a simultaneous software request for counting.
            state    <= ST_ASSERT;
            rstb_out <= '0;
            seq_done <= 1'b0;
            lock_cnt <= '0;
            step_cnt <= '0;
            if (!pll_locked && lock_loss_cnt != 8'hFF)
              lock_loss_cnt <= lock_loss_cnt + 8'd1;
          end else if (state == ST_RELEASE) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              // Shift in a one: releases the next-higher domain, keeps lower ones.
              rstb_out <= {rstb_out[N_DOMAINS-2:0], 1'b1};
              if (rstb_out[N_DOMAINS-2]) begin
                state    <= ST_DONE;
                seq_done <= 1'b1;
              end
            end else begin
              step_cnt <= step_cnt + SW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed vector table, saturation run and random
// stimulus, all checked against a cycle-count based reference model.
module tb_reset_sequencer;
  localparam int N = 4;
  localparam int L = 16;
  localparam int S = 8;

  logic         clk = 1'b0;
  logic         rstb_in = 1'b0;
  logic         pll_locked = 1'b0;
  logic         sw_rst_req = 1'b0;
  logic [N-1:0] rstb_out;
  logic         seq_done;
  logic [1:0]   seq_state;
  logic [7:0]   lock_loss_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: m_t = consecutive qualifying locked edges since the last restart.
  int m_t = 0;
  int m_loss = 0;

  typedef struct {
    int         n;
    bit         r, p, s;
    logic [3:0] o;
    bit         d;
    logic [1:0] st;
    logic [7:0] l;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  reset_sequencer #(.N_DOMAINS(N), .LOCK_STABLE_CYCLES(L), .STEP_CYCLES(S)) dut (
    .clk(clk), .rstb_in(rstb_in), .pll_locked(pll_locked), .sw_rst_req(sw_rst_req),
    .rstb_out(rstb_out), .seq_done(seq_done), .seq_state(seq_state),
    .lock_loss_cnt(lock_loss_cnt)
  );

  function automatic int rel(int t);
    int k;
    if (t < L) return 0;
    k = 1 + (t - L) / S;
    return (k > N) ? N : k;
  endfunction

  function automatic logic [14:0] model_vec();
    int r;
    logic [1:0] st;
    logic [3:0] o;
    r  = rel(m_t);
    o  = 4'((1 << r) - 1);
    st = (r == 0) ? 2'd0 : (r == N) ? 2'd2 : 2'd1;
    return {8'(m_loss), st, (r == N), o};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {lock_loss_cnt, seq_state, seq_done, rstb_out};
  endfunction

  task automatic chk(string name, logic [14:0] act, logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got loss=%0d state=%0d done=%0d rstb_out=%b, expected loss=%0d state=%0d done=%0d rstb_out=%b",
               name, $time, act[14:7], act[6:5], act[4], act[3:0],
               exp[14:7], exp[6:5], exp[4], exp[3:0]);
    end
  endtask

  task automatic step(bit r, bit p, bit s);
    rstb_in = r; pll_locked = p; sw_rst_req = s;
    @(posedge clk);
    if (!r) begin
      m_t = 0; m_loss = 0;
    end else if (!p) begin
      if (rel(m_t) > 0 && m_loss < 255) m_loss++;
      m_t = 0;
    end else if (s) begin
      m_t = 0;
    end else if (m_t < 1000000) begin
      m_t++;
    end
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  // sw is pulsed only on the first edge of each record.
  task automatic add(int n, bit r, bit p, bit s, logic [3:0] o, bit d, logic [1:0] st, logic [7:0] l);
    vec_t v;
    v.n = n; v.r = r; v.p = p; v.s = s; v.o = o; v.d = d; v.st = st; v.l = l;
    tbl.push_back(v);
  endtask

  initial begin
    add( 1, 0, 1, 0,  4'h0, 0, 2'd0, 8'd0);  // reset
    add(15, 1, 1, 0,  4'h0, 0, 2'd0, 8'd0);
    add( 1, 1, 1, 0,  4'h1, 0, 2'd1, 8'd0);  // edge 16
    add( 8, 1, 1, 0,  4'h3, 0, 2'd1, 8'd0);  // edge 24
    add( 8, 1, 1, 0,  4'h7, 0, 2'd1, 8'd0);  // edge 32
    add( 7, 1, 1, 0,  4'h7, 0, 2'd1, 8'd0);
    add( 1, 1, 1, 0,  4'hF, 1, 2'd2, 8'd0);  // edge 40
    add( 5, 1, 1, 0,  4'hF, 1, 2'd2, 8'd0);
    add( 1, 1, 0, 0,  4'h0, 0, 2'd0, 8'd1);  // lock loss in DONE
    add(39, 1, 1, 0,  4'h7, 0, 2'd1, 8'd1);
    add( 1, 1, 1, 0,  4'hF, 1, 2'd2, 8'd1);  // 40 after relock
    add( 1, 1, 1, 1,  4'h0, 0, 2'd0, 8'd1);  // sw in DONE
    add(16, 1, 1, 0,  4'h1, 0, 2'd1, 8'd1);
    add( 8, 1, 1, 0,  4'h3, 0, 2'd1, 8'd1);
    add( 1, 1, 1, 1,  4'h0, 0, 2'd0, 8'd1);  // sw at 0011
    add(15, 1, 1, 0,  4'h0, 0, 2'd0, 8'd1);
    add( 1, 1, 1, 0,  4'h1, 0, 2'd1, 8'd1);
    add(16, 1, 1, 0,  4'h7, 0, 2'd1, 8'd1);
    add( 1, 0, 1, 0,  4'h0, 0, 2'd0, 8'd0);  // rstb_in at 0111
    add(16, 1, 1, 0,  4'h1, 0, 2'd1, 8'd0);
    add( 1, 1, 0, 1,  4'h0, 0, 2'd0, 8'd1);  // sw + lock loss together
    add( 9, 1, 1, 0,  4'h0, 0, 2'd0, 8'd1);
    add( 1, 1, 0, 0,  4'h0, 0, 2'd0, 8'd1);  // drop at edge 10 in ASSERT
    add(15, 1, 1, 0,  4'h0, 0, 2'd0, 8'd1);
    add( 1, 1, 1, 0,  4'h1, 0, 2'd1, 8'd1);  // edge 26
    add( 1, 1, 0, 0,  4'h0, 0, 2'd0, 8'd2);
    add(10, 1, 1, 0,  4'h0, 0, 2'd0, 8'd2);
    add( 1, 1, 1, 1,  4'h0, 0, 2'd0, 8'd2);  // sw in ASSERT restarts window
    add(15, 1, 1, 0,  4'h0, 0, 2'd0, 8'd2);
    add( 1, 1, 1, 0,  4'h1, 0, 2'd1, 8'd2);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++)
        step(tbl[i].r, tbl[i].p, (k == 0) ? tbl[i].s : 1'b0);
      chk($sformatf("vec%0d", i), dut_vec(), {tbl[i].l, tbl[i].st, tbl[i].d, tbl[i].o});
    end

    // Saturation: 300 lock losses, each from DONE.
    step(0, 1, 0);
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 40; k++) step(1, 1, 0);
      if (n == 0) chk("done_before_loss", dut_vec(), {8'd0, 2'd2, 1'b1, 4'hF});
      step(1, 0, 0);
    end
    chk("loss_saturated", {lock_loss_cnt, seq_state, seq_done, rstb_out}, {8'd255, 2'd0, 1'b0, 4'h0});

    // Random stimulus against the model.
    step(0, 1, 0);
    for (int n = 0; n < 6000; n++)
      step($urandom_range(0, 299) != 0, $urandom_range(0, 79) != 0, $urandom_range(0, 119) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
